// File: rtl/hqm_rcfwl_gclk_rlink_pkg.sv
// Shared constants, lane-config type and delay-width helper for the
// multi-lane rlink sync distribution slice.
package hqm_rcfwl_gclk_rlink_pkg;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_MAX_DLY  = 7;
  localparam int DEF_PER_W    = 10;
  localparam int DEF_LOCK_CNT = 4;

  localparam int LANE_DLY_W = 8;
  localparam int MATCH_W    = 4;

  function automatic int dly_w(input int max_dly);
    return (max_dly < 1) ? 1 : $clog2(max_dly + 1);
  endfunction

  typedef struct packed {
    logic                  en;
    logic [LANE_DLY_W-1:0] dly;
  } lane_cfg_t;

endpackage

// File: rtl/hqm_rcfwl_gclk_rlink_sync_dist_if.sv
// Sync source / lane config / status bundle between the PLL sync source
// (master) and the distribution block (slave).
interface hqm_rcfwl_gclk_rlink_sync_dist_if
  import hqm_rcfwl_gclk_rlink_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int DLY_W = dly_w(DEF_MAX_DLY),
  parameter int PER_W = DEF_PER_W
);
  logic                  pll_sync_in;
  logic [N_CH-1:0]       cfg_en;
  logic [N_CH*DLY_W-1:0] cfg_dly;
  logic [PER_W-1:0]      cfg_period;
  logic                  err_clr;
  logic [N_CH-1:0]       pll_sync_out;
  logic                  sync_pulse;
  logic [PER_W-1:0]      period_meas;
  logic                  locked;
  logic                  err_sticky;

  modport master (
    output pll_sync_in, cfg_en, cfg_dly, cfg_period, err_clr,
    input  pll_sync_out, sync_pulse, period_meas, locked, err_sticky
  );

  modport slave (
    input  pll_sync_in, cfg_en, cfg_dly, cfg_period, err_clr,
    output pll_sync_out, sync_pulse, period_meas, locked, err_sticky
  );
endinterface

// File: rtl/hqm_rcfwl_gclk_sync_permon.sv
// Sync period monitor: cycle counter, arming, consecutive-match lock,
// lost-sync timeout and sticky error latch.
module hqm_rcfwl_gclk_sync_permon
  import hqm_rcfwl_gclk_rlink_pkg::*;
#(
  parameter int PER_W    = DEF_PER_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise,
  input  logic [PER_W-1:0] cfg_period,
  input  logic             err_clr,
  output logic [PER_W-1:0] period_meas,
  output logic             locked,
  output logic             err_sticky
);
  localparam logic [MATCH_W-1:0] LOCK_V = MATCH_W'(LOCK_CNT);

  logic [PER_W-1:0]   cyc_cnt;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] match_inc;
  logic               armed;
  logic               err_set_q;
  logic               mon_off;
  logic               cmp;
  logic               timeout;
  logic               miss;

  always_comb begin
    mon_off   = (cfg_period == '0);
    cmp       = rise & armed;
    timeout   = locked & ~rise &
                ({1'b0, cyc_cnt} == ({1'b0, cfg_period} + {{PER_W{1'b0}}, 1'b1}));
    miss      = ~mon_off & ((cmp & (cyc_cnt != cfg_period)) | timeout);
    match_inc = (match_cnt == LOCK_V) ? match_cnt : match_cnt + MATCH_W'(1);
  end

  // Error flag is staged one cycle so it lands after the lock drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt     <= '0;
      match_cnt   <= '0;
      armed       <= 1'b0;
      err_set_q   <= 1'b0;
      period_meas <= '0;
      locked      <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      if (rise)          cyc_cnt <= PER_W'(1);
      else if (~&cyc_cnt) cyc_cnt <= cyc_cnt + PER_W'(1);

      if (rise) armed <= 1'b1;
      if (cmp)  period_meas <= cyc_cnt;

      if (mon_off | miss) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end else if (cmp) begin
        match_cnt <= match_inc;
        locked    <= (match_inc == LOCK_V);
      end

      err_set_q <= miss & locked;
      if (err_set_q)    err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/hqm_rcfwl_gclk_rlink_sync_dist.sv
// Registers the PLL sync level, fans it out through a shared delay line to
// per-lane deskew muxes, and feeds rising edges to the period monitor.
module hqm_rcfwl_gclk_rlink_sync_dist
  import hqm_rcfwl_gclk_rlink_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int MAX_DLY  = DEF_MAX_DLY,
  parameter int PER_W    = DEF_PER_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input logic                             clk,
  input logic                             rst,
  hqm_rcfwl_gclk_rlink_sync_dist_if.slave sif
);
  localparam int DLY_W = dly_w(MAX_DLY);

  logic             in_q;
  logic [MAX_DLY:1] tap_q;
  logic [MAX_DLY:0] tap;
  logic             rise;
  lane_cfg_t        lane_cfg [N_CH];
  logic [N_CH-1:0]  lane_nxt;
  logic [DLY_W-1:0] sel;

  assign tap  = {tap_q, in_q};
  assign rise = in_q & ~tap[1];

  // Out-of-range lane delays clamp to the deepest tap.
  always_comb begin
    lane_cfg = '{default: '0};
    lane_nxt = '0;
    sel      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      lane_cfg[i].en  = sif.cfg_en[i];
      lane_cfg[i].dly = LANE_DLY_W'(sif.cfg_dly[i*DLY_W +: DLY_W]);
      sel = (lane_cfg[i].dly > LANE_DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY)
                                                      : DLY_W'(lane_cfg[i].dly);
      lane_nxt[i] = lane_cfg[i].en & tap[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q             <= 1'b0;
      tap_q            <= '0;
      sif.pll_sync_out <= '0;
      sif.sync_pulse   <= 1'b0;
    end else begin
      in_q             <= sif.pll_sync_in;
      tap_q            <= tap[MAX_DLY-1:0];
      sif.pll_sync_out <= lane_nxt;
      sif.sync_pulse   <= rise;
    end
  end

  hqm_rcfwl_gclk_sync_permon #(
    .PER_W    (PER_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_permon (
    .clk         (clk),
    .rst         (rst),
    .rise        (rise),
    .cfg_period  (sif.cfg_period),
    .err_clr     (sif.err_clr),
    .period_meas (sif.period_meas),
    .locked      (sif.locked),
    .err_sticky  (sif.err_sticky)
  );

endmodule

// File: tb/tb_hqm_rcfwl_gclk_rlink_sync_dist.sv
// Scoreboard bench: two DUT configurations share one stimulus stream; an
// edge-timestamp reference model queues expected outputs per clock edge.
module tb_hqm_rcfwl_gclk_rlink_sync_dist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       pin = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] en  = 4'b1111;
  int         dly [4] = '{0, 3, 7, 7};
  int         per [2] = '{16, 0};

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] lanes;
    logic       pulse;
    int         meas;
    logic       lk;
    logic       err;
  } exp_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int MD  = (g == 0) ? 7 : 5;
    localparam int PW  = (g == 0) ? 10 : 4;
    localparam int LC  = (g == 0) ? 4 : 2;
    localparam int DW  = 3;
    localparam int CAP = (1 << PW) - 1;

    hqm_rcfwl_gclk_rlink_sync_dist_if #(.N_CH(4), .DLY_W(DW), .PER_W(PW)) sif ();

    hqm_rcfwl_gclk_rlink_sync_dist #(
      .N_CH(4), .MAX_DLY(MD), .PER_W(PW), .LOCK_CNT(LC)
    ) dut (
      .clk (clk),
      .rst (rst),
      .sif (sif)
    );

    always_comb begin
      sif.pll_sync_in = pin;
      sif.cfg_en      = en;
      sif.err_clr     = clr;
      sif.cfg_period  = PW'(per[g]);
      sif.cfg_dly     = '0;
      for (int i = 0; i < 4; i++) sif.cfg_dly[i*DW +: DW] = DW'(dly[i]);
    end

    // Reference: sample history, rise timestamps and lock bookkeeping.
    exp_t q[$];
    logic s [0:MD] = '{default: 1'b0};
    logic armed = 1'b0, lk = 1'b0, err = 1'b0, pend = 1'b0;
    int   e = 0, last_e = 0, mcnt = 0, meas = 0;

    always @(posedge clk) begin
      exp_t x;
      int   p, cnt, sel;
      logic rise;
      e++;
      p = per[g] & CAP;
      x.lanes = '0;
      x.pulse = 1'b0;
      if (rst) begin
        for (int j = 0; j <= MD; j++) s[j] = 1'b0;
        armed = 0; lk = 0; err = 0; pend = 0; mcnt = 0; meas = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          sel = (dly[i] > MD) ? MD : dly[i];
          x.lanes[i] = en[i] & s[sel];
        end
        rise = s[0] & ~s[1];
        cnt  = ((e - last_e) > CAP) ? CAP : (e - last_e);
        err  = pend ? 1'b1 : (clr ? 1'b0 : err);
        pend = 1'b0;
        if (rise && armed) meas = cnt;
        if (p == 0) begin
          lk = 0; mcnt = 0;
        end else if (rise && armed) begin
          if (cnt == p) begin
            mcnt = (mcnt < LC) ? mcnt + 1 : LC;
            lk   = (mcnt == LC);
          end else begin
            pend = lk; lk = 0; mcnt = 0;
          end
        end else if (!rise && lk && cnt == p + 1) begin
          pend = 1'b1; lk = 0; mcnt = 0;
        end
        if (rise) begin
          armed  = 1'b1;
          last_e = e;
        end
        x.pulse = rise;
      end
      x.meas = meas;
      x.lk   = lk;
      x.err  = err;
      q.push_back(x);
      for (int j = MD; j > 0; j--) s[j] = s[j-1];
      s[0] = rst ? 1'b0 : pin;
    end

    always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
        x = q.pop_front();
        check($sformatf("h%0d.pll_sync_out", g), 32'(sif.pll_sync_out), 32'(x.lanes));
        check($sformatf("h%0d.sync_pulse", g),   32'(sif.sync_pulse),   32'(x.pulse));
        check($sformatf("h%0d.period_meas", g),  32'(sif.period_meas),  32'(x.meas));
        check($sformatf("h%0d.locked", g),       32'(sif.locked),       32'(x.lk));
        check($sformatf("h%0d.err_sticky", g),   32'(sif.err_sticky),   32'(x.err));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_train(input int period, input int high);
    pin = 1'b1;
    step(high);
    pin = 1'b0;
    step(period - high);
  endtask

  initial begin
    int p;
    rst = 1'b1;
    repeat (3) begin
      pin = ~pin;
      step(1);
    end
    rst = 1'b0;
    pin = 1'b0;
    step(4);

    // first rise only arms; single-rise deskew with all lanes, then lane 2 off
    pulse_train(20, 2);
    en = 4'b1011;
    pulse_train(20, 2);
    en = 4'b1111;

    // lock, period error, relock, clear
    repeat (6) pulse_train(16, 4);
    pulse_train(17, 4);
    repeat (5) pulse_train(16, 4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    repeat (5) pulse_train(16, 4);

    // lost sync with clear held across the error set
    clr = 1'b1;
    step(30);
    clr = 1'b0;

    // narrow instance: lock at 12, clamp of delay 7, counter saturation
    per[1] = 12;
    dly = '{7, 7, 5, 2};
    repeat (4) pulse_train(12, 3);
    step(40);
    pulse_train(12, 3);
    pulse_train(12, 3);

    repeat (150) begin
      case ($urandom_range(0, 19))
        0: begin rst = 1'b1; step($urandom_range(1, 2)); rst = 1'b0; end
        1: per[0] = ($urandom_range(0, 3) == 0) ? 0 : 16;
        2: per[1] = ($urandom_range(0, 3) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 12 : 15);
        3: begin
          en = 4'($urandom_range(0, 15));
          for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 7);
        end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        clr = 1'b1;
        step(1);
        clr = 1'b0;
      end
      case ($urandom_range(0, 7))
        0, 1, 2: p = 16;
        3:       p = 17;
        4:       p = 15;
        5, 6:    p = 12;
        default: p = $urandom_range(2, 40);
      endcase
      pulse_train(p, $urandom_range(1, p - 1));
    end

    step(12);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hqm_rcfwl_gclk_rlink_sync_dist.md
# hqm_rcfwl_gclk_rlink_sync_dist

Parametrised multi-channel successor to the single-lane rlink logic-PHY sync passthrough. Registers the PLL sync strobe once, fans it out to N_CH rlink lanes, each with its own programmable delay (lane deskew) and enable, and monitors the sync period to report lock and sticky error status. Sits between the global-clock PLL sync source and the rlink logic-PHY lanes. Clock-spine distribution stays outside this block.

## Interface
Parameters:
- N_CH, 4: number of sync output lanes (1..32).
- MAX_DLY, 7: maximum per-lane delay in cycles. DLY_W = $clog2(MAX_DLY+1).
- PER_W, 10: width of the period counter and config.
- LOCK_CNT, 4: consecutive matching periods required to assert locked (1..15).

Ports:
- clk  in  1  block clock. Single clock domain.
- rst  in  1  reset, synchronous, active-high.
- pll_sync_in  in  1  PLL sync level, synchronous to clk.
- cfg_en  in  N_CH  per-lane output enable.
- cfg_dly  in  N_CH*DLY_W  per-lane delay. Lane i uses bits [i*DLY_W +: DLY_W].
- cfg_period  in  PER_W  expected period in cycles. 0 disables the monitor.
- err_clr  in  1  clears err_sticky.
- pll_sync_out  out  N_CH  delayed sync level per lane.
- sync_pulse  out  1  one-cycle pulse on each detected rising edge.
- period_meas  out  PER_W  last measured period.
- locked  out  1  period lock status.
- err_sticky  out  1  lock-loss or period error latch.

## Operation
- Input stage: in_q <= pll_sync_in.
- Delay line: tap[0] = in_q; tap[j] <= tap[j-1] for j = 1..MAX_DLY.
- Lane output: pll_sync_out[i] <= cfg_en[i] ? tap[sel] : 0.
  - sel = cfg_dly[i] when cfg_dly[i] <= MAX_DLY, else MAX_DLY (clamp).
- Edge detect: rise = in_q & ~tap[1]. sync_pulse <= rise.
- Period counter cyc_cnt:
  - On rise: cyc_cnt <= 1.
  - Otherwise: cyc_cnt increments, saturating at all-ones.
- armed flag: set by the first rise after reset. Until armed, no compare is done and period_meas is not updated.
- On rise while armed:
  - period_meas <= cyc_cnt.
  - If cyc_cnt == cfg_period (match): match_cnt increments, saturating at LOCK_CNT. locked <= 1 when the incremented value reaches LOCK_CNT.
  - On mismatch: match_cnt <= 0 and locked <= 0. If locked was 1, err_sticky <= 1.
- Timeout: while locked, cyc_cnt reaching cfg_period+1 with no rise is a lost sync. Apply the mismatch action (locked <= 0, match_cnt <= 0, err_sticky <= 1).
- cfg_period == 0: locked forced 0, match_cnt held 0, no errors raised. period_meas still updates.
- A saturated cyc_cnt never matches a nonzero cfg_period below all-ones.
- err_clr: clears err_sticky. A simultaneous set wins over the clear.
- Config changes take effect on the next edge with no protection. Software quiesces lanes before changing cfg_dly.

## Timing
- Reset values (after the first rst edge): pll_sync_out = 0, sync_pulse = 0, period_meas = 0, locked = 0, err_sticky = 0. Internal: taps = 0, cyc_cnt = 0, match_cnt = 0, armed = 0.
- rst asserted mid-operation drops all state at the next edge. Pulses already in the delay line are discarded.
- Lane latency: a level sampled at edge n appears on pll_sync_out[i] after edge n+1+cfg_dly[i].
- sync_pulse: asserted for one cycle after edge n+1 when the level sampled at edge n is a rising edge.
- period_meas and locked update in the same cycle sync_pulse is asserted.
- err_sticky sets in the cycle after the mismatch compare.
- Lock latency: the first rise only arms. Each of the next LOCK_CNT rises must match cfg_period, so locked asserts with the (LOCK_CNT+1)-th rise.

## Structure
- Package hqm_rcfwl_gclk_rlink_pkg holds:
  - a localparam function for DLY_W;
  - the lane-config struct typedef {en, dly};
  - the default constants.
- Sub-module hqm_rcfwl_gclk_sync_permon contains the counter, armed flag, match counter, locked/err logic and timeout.
- The top level holds the input register, the delay line and the lane muxes.
- All registers are plain always_ff with synchronous rst.

## Test plan
1. Reset: hold rst 3 cycles while toggling pll_sync_in -> all outputs 0. After release, first rise gives sync_pulse but locked stays 0 and period_meas stays 0.
2. Deskew: cfg_dly={0,3,7,7}, cfg_en=4'b1111, single rise sampled at edge 10 -> lanes rise after edges 11, 14, 18, 18. Repeat with cfg_en=4'b1011 -> lane 2 stays 0.
3. Lock: cfg_period=16, rise every 16 cycles -> locked=1 at the 5th rise, period_meas=16, err_sticky=0.
4. Period error: after lock, one period of 17 -> locked=0 and period_meas=17 at that rise, err_sticky=1 next cycle. Relock after 4 matching periods. err_clr pulse -> err_sticky=0.
5. Timeout and clear race: after lock, stop pll_sync_in -> locked drops and err_sticky sets when cyc_cnt reaches 17. Assert err_clr in the same cycle as a new error -> err_sticky stays 1.
6. Saturation and clamp: PER_W=4, no sync for 40 cycles -> cyc_cnt holds 15 and the next rise gives period_meas=15. cfg_dly=7 with MAX_DLY=5 -> behaves as delay 5.
